// File: rtl/prefix_subtractor_if.sv
// Operand/result handshake bundle for prefix_subtractor.
// master = producer/consumer side (bench), slave = the pipeline.
interface prefix_subtractor_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Diff;
  logic        borrow;
  logic        ovf;
  logic        zero;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Diff, borrow, ovf, zero
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Diff, borrow, ovf, zero
  );
endinterface

// File: rtl/prefix_subtractor.sv
// 32-bit add/subtract, Kogge-Stone carry network, 3 register stages.
//   S1: bitwise generate/propagate, carry-in = op
//   S2: prefix levels with spans 1, 2, 4
//   S3: prefix levels with spans 8, 16, sum XOR and flags
// Whole pipe advances on adv = !out_valid | out_ready, holds otherwise.
module prefix_subtractor (
  input  logic               clk,
  input  logic               rst,
  prefix_subtractor_if.slave bus
);
  localparam int W      = 32;
  localparam int STAGES = 3;

  // group generate/propagate vectors for one prefix level
  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] p;
  } gp_t;

  // data carried between stages; pb is the bitwise propagate kept for the sum
  typedef struct packed {
    gp_t          gp;
    logic [W-1:0] pb;
    logic         cin;
    logic         a_msb;
  } stage_t;

  // one Kogge-Stone level: bit i combines with bit i-span; bits below
  // span pass through (their shifted-in p is forced to 1, g to 0)
  function automatic gp_t ks_level(input gp_t x, input int span);
    gp_t y;
    y.g = x.g | (x.p & (x.g << span));
    y.p = x.p & ((x.p << span) | ~({W{1'b1}} << span));
    return y;
  endfunction

  logic              adv;
  logic [STAGES:1]   vld_pipe;
  logic [W-1:0]      bx;
  stage_t            s1_d, s1_q;
  stage_t            s2_d, s2_q;
  gp_t               l5;
  logic [W-1:0]      carry;
  logic [W-1:0]      sum;
  logic              cout;
  logic              borrow_d, ovf_d, zero_d;
  logic [W-1:0]      diff_q;
  logic              borrow_q, ovf_q, zero_q;

  assign adv           = !vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.Diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  // S1 inputs: invert B for subtraction, carry-in supplies the +1
  always_comb begin
    s1_d       = '0;
    bx         = bus.B ^ {W{bus.op}};
    s1_d.gp.g  = bus.A & bx;
    s1_d.gp.p  = bus.A ^ bx;
    s1_d.pb    = bus.A ^ bx;
    s1_d.cin   = bus.op;
    s1_d.a_msb = bus.A[W-1];
  end

  // S2 inputs: first three prefix levels on the registered S1 vectors
  always_comb begin
    s2_d       = s1_q;
    s2_d.gp    = ks_level(ks_level(ks_level(s1_q.gp, 1), 2), 4);
  end

  // S3: last two prefix levels, fold in carry-in, form sum and flags
  always_comb begin
    l5       = ks_level(ks_level(s2_q.gp, 8), 16);
    carry    = l5.g | (l5.p & {W{s2_q.cin}});
    sum      = s2_q.pb ^ {carry[W-2:0], s2_q.cin};
    cout     = carry[W-1];
    // cin doubles as op: subtraction reports borrow as inverted carry
    borrow_d = s2_q.cin ? ~cout : cout;
    // operand signs equal (pb msb clear) and result sign differs
    ovf_d    = ~s2_q.pb[W-1] & (sum[W-1] ^ s2_q.a_msb);
    zero_d   = ~|sum;
  end

  // valid shift register; only state that must be clean out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_pipe <= '0;
    else if (adv)
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // S1/S2 data registers; contents of invalid stages are don't-care
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // S3 result registers; only loaded by a valid result so they hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (adv && vld_pipe[STAGES-1]) begin
      diff_q   <= sum;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_prefix_subtractor.sv
// Bench for prefix_subtractor: table vectors, stall/reset sequences and a
// random run, all checked through an expected-result queue.
module tb_prefix_subtractor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefix_subtractor_if bus();
  prefix_subtractor dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    res_t        exp;
  } vec_t;

  res_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   rnd_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: plain arithmetic, unsigned compare and signed range test
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t        x;
    logic [32:0] s;
    longint      sa, sbv, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op) begin
      x.diff   = a - b;
      x.borrow = (a < b);
      r        = sa - sbv;
    end else begin
      s        = {1'b0, a} + {1'b0, b};
      x.diff   = s[31:0];
      x.borrow = s[32];
      r        = sa + sbv;
    end
    x.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    x.zero = (x.diff == 32'h0);
    return x;
  endfunction

  function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] b, input logic op,
                               input logic [31:0] d, input logic br, input logic ov, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.op = op;
    v.exp.diff = d; v.exp.borrow = br; v.exp.ovf = ov; v.exp.zero = z;
    return v;
  endfunction

  // present one operand pair, push its expectation when it is accepted
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input res_t exp);
    int n    = 0;
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.A = a; bus.B = b; bus.op = op;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb_q.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 200) begin
        errors++; checks++;
        $display("FAIL send_timeout: got no in_ready expected accept within 200 cycles");
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic latency_check(input string nm);
    int n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n, 3);
  endtask

  // output monitor: pops expectations on handshake, checks hold while stalled
  res_t cur, prev, expv;
  bit   prev_stall = 0;
  initial forever begin
    @(negedge clk);
    cur = {bus.Diff, bus.borrow, bus.ovf, bus.zero};
    if (rst) begin
      sb_q.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", cur, prev);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_result: got %h expected none", cur);
        end else begin
          expv = sb_q.pop_front();
          chk("result", cur, expv);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = cur;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before 600000");
    $fatal(1, "watchdog");
  end

  vec_t        vecs[11];
  logic [31:0] ra, rb;
  logic        rop;

  initial begin
    vecs[0]  = mkv(32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mkv(32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mkv(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    vecs[3]  = mkv(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mkv(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mkv(32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mkv(32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mkv(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mkv(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
    vecs[9]  = mkv(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    vecs[10] = mkv(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);

    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.op = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // reset state
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_outputs", {bus.Diff, bus.borrow, bus.ovf, bus.zero}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // first result latency on an empty pipe
    bus.out_ready = 1'b1;
    send(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].exp);
    latency_check("latency");
    drain();

    // table vectors back to back
    for (int i = 0; i < 11; i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    drain();

    // five back-to-back inputs with a three-cycle output stall
    fork
      begin
        for (int k = 0; k < 5; k++)
          send(32'(k * 1000), 32'(k), 1'b1, model(32'(k * 1000), 32'(k), 1'b1));
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_out_valid", bus.out_valid, 1);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // reset with two results in flight, one already waiting at the output
    bus.out_ready = 1'b0;
    send(32'h00000010, 32'h00000003, 1'b1, model(32'h00000010, 32'h00000003, 1'b1));
    send(32'h00000020, 32'h00000005, 1'b0, model(32'h00000020, 32'h00000005, 1'b0));
    @(posedge clk); #1;
    chk("pre_reset_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", bus.out_valid, 0);
    chk("async_reset_in_ready", bus.in_ready, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_after_reset", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    send(32'hDEADBEEF, 32'h0000BEEF, 1'b1, model(32'hDEADBEEF, 32'h0000BEEF, 1'b1));
    latency_check("latency_after_reset");
    drain();

    // random operands with random input gaps and output back-pressure
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          ra  = $urandom;
          rb  = ($urandom_range(0, 15) == 0) ? ra : $urandom;
          rop = 1'($urandom_range(0, 1));
          send(ra, rb, rop, model(ra, rb, rop));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prefix_subtractor.md
PREFIX_SUBTRACTOR -- requirements
Module: prefix_subtractor

Interface
REQ-001 Parameter: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operand pair on A/B/op is valid this cycle.
REQ-005 in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 A  input  32  minuend (op=1) or addend (op=0).
REQ-007 B  input  32  subtrahend (op=1) or addend (op=0).
REQ-008 op  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result fields are valid this cycle.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Diff  output  32  result, modulo 2^32.
REQ-012 borrow  output  1  op=1: unsigned A<B; op=0: unsigned carry-out.
REQ-013 ovf  output  1  two's-complement signed overflow of the selected operation.
REQ-014 zero  output  1  Diff == 0.

Function
REQ-015 Computation SHALL be A + (B XOR {32{op}}) + op, using a Kogge-Stone parallel-prefix carry network; no ripple-carry chain.
REQ-016 Pipeline SHALL have exactly 3 register stages: S1 = bitwise generate/propagate with carry-in op; S2 = prefix levels 1-3 (spans 1, 2, 4); S3 = prefix levels 4-5 (spans 8, 16) plus sum XOR and flags.
REQ-017 Latency SHALL be 3 cycles from an accepted input (in_valid & in_ready) to out_valid with no stall.
REQ-018 Pipeline advance signal adv = !out_valid | out_ready; all stages SHALL move together when adv=1 and hold when adv=0.
REQ-019 in_ready SHALL equal adv, combinationally.
REQ-020 Each stage SHALL carry a valid bit; a cycle with adv=1 and in_valid=0 SHALL inject a bubble (S1 valid=0).
REQ-021 Sustained throughput SHALL be one result per cycle while out_ready=1.
REQ-022 out_valid, Diff, borrow, ovf and zero SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 borrow SHALL be the inverted carry-out of bit 31 when op=1 and the carry-out itself when op=0.
REQ-024 ovf SHALL be (A[31] == Bx[31]) & (Diff[31] != A[31]), where Bx = B XOR {32{op}}.
REQ-025 zero SHALL be computed from the registered Diff of the same result.
REQ-026 Data registers of invalid stages are don't-care; only the valid bits are reset.
REQ-027 Simultaneous input accept and output accept in one cycle SHALL lose no result and duplicate none.

Reset
REQ-028 While rst=1, all stage valid bits and out_valid SHALL be 0, independent of clk.
REQ-029 Reset reached mid-operation SHALL discard all in-flight results; no result is emitted for operands accepted before reset.
REQ-030 in_ready SHALL be 1 during and immediately after reset, because out_valid=0.
REQ-031 Diff, borrow, ovf and zero SHALL reset to 0.

Verification
REQ-032 A=00000001, B=00000001, op=1, out_ready=1 -> 3 cycles later, Diff=00000000, zero=1, borrow=0, ovf=0.
REQ-033 A=00000000, B=00000001, op=1 -> Diff=FFFFFFFF, borrow=1, ovf=0, zero=0; and A=FFFFFFFF, B=00000001, op=0 -> Diff=00000000, borrow=1, zero=1.
REQ-034 A=80000000, B=00000001, op=1 -> Diff=7FFFFFFF, ovf=1, borrow=0; A=7FFFFFFF, B=00000001, op=0 -> Diff=80000000, ovf=1.
REQ-035 Back-to-back: 5 consecutive inputs (k=0..4: A=k*1000, B=k, op=1) with out_ready held 0 for cycles 4-6 -> in_ready=0 during the stall; all 5 results emerge in order with no loss or duplication and stay stable while stalled.
REQ-036 Reset mid-stream: rst asserted 1 cycle after 2 accepted inputs -> out_valid=0 immediately; no stale output after release; the next input yields the correct result after 3 cycles.
REQ-037 Random: 10k random A/B/op with random in_valid/out_ready -> every result matches the reference model (A±B, flags), order preserved.
